mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 193 +++++++++++++++++++
 tb/tb_mem_io_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Byte-wide CPU memory/IO responder.
//   - RAM: 2**ADDR_WIDTH bytes, 0-cycle write, 1-cycle registered read.
//   - IO window (mem_a[17:16] == 2'b11):
//       0x30000 write: push a non-zero byte into the UART TX FIFO (0x00 ignored)
//       0x30000 read : rx_data if rx_valid (rx_ready strobes), else 0x00
//       0x30004 write: set sticky prog_stop and push 0x00 into the TX FIFO
//       0x30004..7 read: cycle counter bytes (0x30004 snapshots the live value)
//       other IO addresses read 0x00 and ignore writes
//   Optional feature macro: CYCLE_COUNTER_EN (cycle counter + snapshot).
//   Without it, reads of 0x30004..0x30007 return 0x00.
// Ports:
//   clk_in, rst_in (async, active-high)
//   mem_a, mem_wr, mem_dout  : CPU request
//   mem_din                  : registered read data
//   tx_data/tx_valid/tx_ready: UART TX handshake, io_buffer_full = FIFO full
//   rx_data/rx_valid/rx_ready: UART RX handshake
//   prog_stop                : sticky stop flag
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop
);

  localparam int          PW        = $clog2(TX_DEPTH);
  localparam logic [PW:0] DEPTH_C   = (PW+1)'(TX_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = (PW)'(1);
  localparam logic [PW:0] CNT_ONE   = (PW+1)'(1);
  localparam logic [31:0] IO_UART_A = 32'h0003_0000;
  localparam logic [31:0] IO_STOP_A = 32'h0003_0004;
  localparam logic [31:0] IO_CYC1_A = 32'h0003_0005;
  localparam logic [31:0] IO_CYC2_A = 32'h0003_0006;
  localparam logic [31:0] IO_CYC3_A = 32'h0003_0007;

  logic [7:0] ram_mem  [0:(2**ADDR_WIDTH)-1];
  logic [7:0] fifo_mem [0:TX_DEPTH-1];

  logic                  io_sel_s;
  logic [ADDR_WIDTH-1:0] ram_idx_s;
  logic                  ram_we_s;
  logic                  push_req_s;
  logic                  push_ok_s;
  logic                  pop_s;
  logic [7:0]            push_data_s;
  logic                  rx_rd_s;

  logic [7:0]    mem_din_q,   mem_din_d;
  logic          prog_stop_q, prog_stop_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [PW:0]   count_q,     count_d;
`ifdef CYCLE_COUNTER_EN
  logic [31:0]   cycle_q,     cycle_d;
  logic [31:0]   snap_q,      snap_d;
`endif

  assign io_sel_s  = (mem_a[17:16] == 2'b11);
  assign ram_idx_s = mem_a[ADDR_WIDTH-1:0];

  // Request decode: RAM/IO read data, RAM write enable, FIFO push request, stop flag.
  always_comb begin
    mem_din_d   = 8'h00;
    ram_we_s    = 1'b0;
    push_req_s  = 1'b0;
    push_data_s = 8'h00;
    rx_rd_s     = 1'b0;
    prog_stop_d = prog_stop_q;
`ifdef CYCLE_COUNTER_EN
    cycle_d     = cycle_q + 32'd1;
    snap_d      = snap_q;
`endif
    if (!io_sel_s) begin
      if (mem_wr) begin
        ram_we_s = 1'b1;
      end else begin
        mem_din_d = ram_mem[ram_idx_s];
      end
    end else if (mem_wr) begin
      if (mem_a == IO_UART_A) begin
        // A zero byte is a no-op so software can poll-write harmlessly.
        if (mem_dout != 8'h00) begin
          push_req_s  = 1'b1;
          push_data_s = mem_dout;
        end else begin
          push_req_s  = 1'b0;
        end
      end else if (mem_a == IO_STOP_A) begin
        prog_stop_d = 1'b1;
        push_req_s  = 1'b1;
        push_data_s = 8'h00;
      end else begin
        push_req_s  = 1'b0;
      end
    end else begin
      case (mem_a)
        IO_UART_A: begin
          if (rx_valid) begin
            rx_rd_s   = 1'b1;
            mem_din_d = rx_data;
          end else begin
            mem_din_d = 8'h00;
          end
        end
`ifdef CYCLE_COUNTER_EN
        // Byte 0 comes from the live counter; bytes 1..3 from the snapshot taken here.
        IO_STOP_A: begin
          mem_din_d = cycle_q[7:0];
          snap_d    = cycle_q;
        end
        IO_CYC1_A: mem_din_d = snap_q[15:8];
        IO_CYC2_A: mem_din_d = snap_q[23:16];
        IO_CYC3_A: mem_din_d = snap_q[31:24];
`endif
        default:   mem_din_d = 8'h00;
      endcase
    end
  end

  // TX FIFO control: a push into a full FIFO succeeds only if a pop frees a slot this cycle.
  always_comb begin
    pop_s     = (count_q != '0) && tx_ready;
    push_ok_s = push_req_s && ((count_q != DEPTH_C) || pop_s);
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = pop_s     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din_q   <= 8'h00;
      prog_stop_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef CYCLE_COUNTER_EN
      cycle_q     <= 32'd0;
      snap_q      <= 32'd0;
`endif
    end else begin
      mem_din_q   <= mem_din_d;
      prog_stop_q <= prog_stop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef CYCLE_COUNTER_EN
      cycle_q     <= cycle_d;
      snap_q      <= snap_d;
`endif
    end
  end

  // RAM array: deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_mem[ram_idx_s] <= mem_dout;
    end
  end

  // FIFO storage: only pointers/count are reset, data slots need no reset.
  always_ff @(posedge clk_in) begin
    if (push_ok_s) begin
      fifo_mem[wr_ptr_q] <= push_data_s;
    end
  end

  assign mem_din        = mem_din_q;
  assign prog_stop      = prog_stop_q;
  assign tx_valid       = (count_q != '0);
  assign io_buffer_full = (count_q == DEPTH_C);
  assign tx_data        = fifo_mem[rd_ptr_q];
  // Consume strobe must land in the request cycle, so it is decoded directly; held low in reset.
  assign rx_ready       = rx_rd_s && !rst_in;

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: table of one-cycle vectors plus hand-written
// sequences for mid-operation reset and the cycle counter.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_stop;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A_UART = 32'h0003_0000;
  localparam logic [31:0] A_STOP = 32'h0003_0004;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .prog_stop(prog_stop)
  );

  always #5 clk_in = ~clk_in;

`ifdef CYCLE_COUNTER_EN
  // Reference count of rising edges since reset release.
  logic [31:0] tb_cyc;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic        txr;
    logic [7:0]  rxd;
    logic        rxv;
    logic        chk_din;
    logic [7:0]  din;
    logic        full;
    logic        txv;
    logic [7:0]  txd;
    logic        ps;
    logic        rxr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic [31:0] a, logic wr,
                              logic [7:0] dout, logic txr, logic [7:0] rxd, logic rxv,
                              logic chk_din, logic [7:0] din, logic full, logic txv,
                              logic [7:0] txd, logic ps, logic rxr);
    vec_t v;
    v.name = name; v.rst = rst; v.a = a; v.wr = wr; v.dout = dout; v.txr = txr;
    v.rxd = rxd; v.rxv = rxv; v.chk_din = chk_din; v.din = din; v.full = full;
    v.txv = txv; v.txd = txd; v.ps = ps; v.rxr = rxr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] a, logic wr, logic [7:0] dout, logic txr);
    mem_a = a; mem_wr = wr; mem_dout = dout; tx_ready = txr;
  endtask

  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] exp_snap;

  initial begin
    rst_in = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    exp_snap = 32'h0;

    // name rst addr wr dout txr rxd rxv | chk_din din full txv txd ps rxr
    vecs.push_back(mk("reset",      1, A_UART,     0, 8'h00, 0, 8'h7E, 1, 1, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("ram_wr",     0, 32'h10,     1, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("ram_rd",     0, 32'h10,     0, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("ram_wr_top", 0, 32'h1FFFF,  1, 8'h5A, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("ram_rd_top", 0, 32'h1FFFF,  0, 8'h00, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("ram_rd_10",  0, 32'h10,     0, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("ram_wr_1",   0, 32'h1,      1, 8'h33, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("ram_alias",  0, 32'h20001,  0, 8'h00, 0, 8'h00, 0, 1, 8'h33, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("tx_zero",    0, A_UART,     1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("rx_valid",   0, A_UART,     0, 8'h00, 0, 8'h7E, 1, 1, 8'h7E, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk("rx_empty",   0, A_UART,     0, 8'h00, 0, 8'h7E, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("io_oth_wr",  0, 32'h30008,  1, 8'h77, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("io_oth_rd",  0, 32'h30008,  0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0));
    // Nine pushes with no pop: full after the 8th, 9th dropped, then exactly 8 drain.
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk("fill", 0, A_UART, 1, 8'h41, 0, 8'h00, 0, 0, 8'h00, (i >= 7), 1, 8'h41, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("drain", 0, 32'h10, 0, 8'h00, 1, 8'h00, 0, 1, 8'hA5, 0, (i < 7), 8'h41, 0, 0));
    // Refill, then push+pop while full, then drain: tail byte must be 0x42.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("fill2", 0, A_UART, 1, 8'h41, 0, 8'h00, 0, 0, 8'h00, (i == 7), 1, 8'h41, 0, 0));
    vecs.push_back(mk("pushpop_full", 0, A_UART, 1, 8'h42, 1, 8'h00, 0, 0, 8'h00, 1, 1, 8'h41, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("drain2", 0, 32'h10, 0, 8'h00, 1, 8'h00, 0, 1, 8'hA5, 0, (i < 7),
                        (i == 6) ? 8'h42 : 8'h41, 0, 0));
    vecs.push_back(mk("tx_zero2",   0, A_UART,     1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("stop_wr",    0, A_STOP,     1, 8'h99, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 1, 0));
    vecs.push_back(mk("stop_pop",   0, 32'h10,     0, 8'h00, 1, 8'h00, 0, 1, 8'hA5, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk("stop_stick", 0, 32'h30008,  1, 8'h55, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0));

    @(negedge clk_in);
    foreach (vecs[i]) begin
      rst_in = vecs[i].rst;
      drive(vecs[i].a, vecs[i].wr, vecs[i].dout, vecs[i].txr);
      rx_data = vecs[i].rxd; rx_valid = vecs[i].rxv;
      #1;
      check($sformatf("%s[%0d].rx_ready", vecs[i].name, i), {31'b0, rx_ready}, {31'b0, vecs[i].rxr});
      @(posedge clk_in);
      @(negedge clk_in);
      if (vecs[i].chk_din)
        check($sformatf("%s[%0d].mem_din", vecs[i].name, i), {24'b0, mem_din}, {24'b0, vecs[i].din});
      check($sformatf("%s[%0d].full", vecs[i].name, i), {31'b0, io_buffer_full}, {31'b0, vecs[i].full});
      check($sformatf("%s[%0d].tx_valid", vecs[i].name, i), {31'b0, tx_valid}, {31'b0, vecs[i].txv});
      if (vecs[i].txv)
        check($sformatf("%s[%0d].tx_data", vecs[i].name, i), {24'b0, tx_data}, {24'b0, vecs[i].txd});
      check($sformatf("%s[%0d].prog_stop", vecs[i].name, i), {31'b0, prog_stop}, {31'b0, vecs[i].ps});
    end
    rx_valid = 1'b0;

    // Reset mid-operation: 3 queued bytes, a read in flight, prog_stop set.
    for (int k = 1; k <= 3; k++) begin
      drive(A_UART, 1'b1, 8'(k), 1'b0);
      @(posedge clk_in);
      @(negedge clk_in);
    end
    check("rst_pre.tx_valid", {31'b0, tx_valid}, 32'd1);
    check("rst_pre.tx_data", {24'b0, tx_data}, 32'h01);
    drive(32'h10, 1'b0, 8'h00, 1'b0);
    @(posedge clk_in);
    #2;
    check("rst_pre.mem_din", {24'b0, mem_din}, 32'hA5);
    rst_in = 1'b1;
    #1;
    check("rst_mid.tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_mid.mem_din", {24'b0, mem_din}, 32'h00);
    check("rst_mid.prog_stop", {31'b0, prog_stop}, 32'd0);
    check("rst_mid.full", {31'b0, io_buffer_full}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst_post.ram_10", {24'b0, mem_din}, 32'hA5);
    check("rst_post.tx_valid", {31'b0, tx_valid}, 32'd0);
    drive(32'h1FFFF, 1'b0, 8'h00, 1'b0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst_post.ram_top", {24'b0, mem_din}, 32'h5A);

    // Cycle counter: fresh reset, 100 idle cycles, then read the four counter bytes.
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(32'h10, 1'b0, 8'h00, 1'b0);
    repeat (100) @(negedge clk_in);
`ifdef CYCLE_COUNTER_EN
    exp_snap = tb_cyc;
`endif
    drive(A_STOP, 1'b0, 8'h00, 1'b0);
    @(posedge clk_in); @(negedge clk_in); b0 = mem_din;
    drive(A_STOP + 32'd1, 1'b0, 8'h00, 1'b0);
    @(posedge clk_in); @(negedge clk_in); b1 = mem_din;
    drive(A_STOP + 32'd2, 1'b0, 8'h00, 1'b0);
    @(posedge clk_in); @(negedge clk_in); b2 = mem_din;
    drive(A_STOP + 32'd3, 1'b0, 8'h00, 1'b0);
    @(posedge clk_in); @(negedge clk_in); b3 = mem_din;
`ifdef CYCLE_COUNTER_EN
    check("cyc.snapshot", {b3, b2, b1, b0}, exp_snap);
    check("cyc.near_100", {31'b0, (exp_snap >= 32'd95 && exp_snap <= 32'd105)}, 32'd1);
`else
    check("cyc.byte0", {24'b0, b0}, 32'h00);
    check("cyc.byte1", {24'b0, b1}, 32'h00);
    check("cyc.byte2", {24'b0, b2}, 32'h00);
    check("cyc.byte3", {24'b0, b3}, 32'h00);
`endif
    check("cyc.prog_stop", {31'b0, prog_stop}, 32'd0);
    check("cyc.tx_valid", {31'b0, tx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
